rr_ring_arbiter: RTL and testbench

- Round-robin arbiter that shares one downstream resource (e.g. a ring counter or shift datapath) among WIDTH requesters.
- Priority is kept as a one-hot token that rotates like a ring counter.
- Issues one registered one-hot grant at a time and enforces a maximum hold time per grant.
- Sits between the requesting blocks and the shared resource; grant/grant_idx drive the resource's select or enable.

---
 rtl/rr_ring_arbiter.sv | 107 ++++++++++
 tb/tb_rr_ring_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/rr_ring_arbiter.sv
// Round-robin arbiter with a rotating one-hot priority token, a registered
// one-hot grant and a per-grant hold-time limit that preempts long holders.
module rr_ring_arbiter #(
   parameter int WIDTH    = 4,
   parameter int MAX_HOLD = 8,
   parameter int IDX_W    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] req,
   input  logic [WIDTH-1:0] done,
   output logic [WIDTH-1:0] grant,
   output logic             grant_valid,
   output logic [IDX_W-1:0] grant_idx,
   output logic [WIDTH-1:0] token,
   output logic             preempt
);

   localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

   typedef enum logic {IDLE, GRANT} state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  grant_q, grant_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [WIDTH-1:0]  token_q, token_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              preempt_q, preempt_d;

   // Handshake: a requester holds req high until it is granted and served;
   // the grantee ends its grant with done or by dropping req, otherwise the
   // arbiter takes the grant back after MAX_HOLD cycles.
   logic [WIDTH-1:0] upper_req, upper_pick, any_pick, pick;
   logic [IDX_W-1:0] pick_idx;
   logic             own_done, own_req, timeout;

   // Requests at or above the token bit win first; otherwise wrap to bit 0.
   always_comb begin
      upper_req  = req & ~(token_q - WIDTH'(1));
      upper_pick = upper_req & (~upper_req + WIDTH'(1));
      any_pick   = req & (~req + WIDTH'(1));
      pick       = (upper_req != '0) ? upper_pick : any_pick;
      pick_idx   = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (pick[i]) pick_idx = IDX_W'(i);
      end
   end

   assign own_done = |(done & grant_q);
   assign own_req  = |(req & grant_q);
   assign timeout  = (hold_q == HOLD_W'(MAX_HOLD - 1));

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      idx_d     = idx_q;
      token_d   = token_q;
      hold_d    = hold_q;
      preempt_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (req != '0) begin
               grant_d = pick;
               idx_d   = pick_idx;
               hold_d  = '0;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (own_done || !own_req || timeout) begin
               grant_d   = '0;
               token_d   = {grant_q[WIDTH-2:0], grant_q[WIDTH-1]};
               preempt_d = timeout && !own_done && own_req;
               state_d   = IDLE;
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         idx_q     <= '0;
         token_q   <= WIDTH'(1);
         hold_q    <= '0;
         preempt_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         idx_q     <= idx_d;
         token_q   <= token_d;
         hold_q    <= hold_d;
         preempt_q <= preempt_d;
      end
   end

   assign grant       = grant_q;
   assign grant_valid = |grant_q;
   assign grant_idx   = idx_q;
   assign token       = token_q;
   assign preempt     = preempt_q;

endmodule

// File: tb/tb_rr_ring_arbiter.sv
// Directed bench for rr_ring_arbiter: a cycle-by-cycle vector table plus
// hand-written reset, timeout and simultaneous-release sequences.
module tb_rr_ring_arbiter;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [3:0] done;
   logic [3:0] grant;
   logic       grant_valid;
   logic [1:0] grant_idx;
   logic [3:0] token;
   logic       preempt;

   int checks;
   int errors;

   rr_ring_arbiter #(.WIDTH(4), .MAX_HOLD(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .done        (done),
      .grant       (grant),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx),
      .token       (token),
      .preempt     (preempt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] req;
      logic [3:0] done;
      logic [3:0] grant;
      logic [1:0] idx;
      logic [3:0] token;
      logic       preempt;
   } vec_t;

   vec_t vecs[23];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string name, input logic [3:0] g, input logic [1:0] idx,
                            input logic [3:0] tok, input logic pre);
      check({name, ".grant"}, 32'(grant), 32'(g));
      check({name, ".valid"}, 32'(grant_valid), 32'(|g));
      check({name, ".idx"}, 32'(grant_idx), 32'(idx));
      check({name, ".token"}, 32'(token), 32'(tok));
      check({name, ".preempt"}, 32'(preempt), 32'(pre));
   endtask

   initial begin
      checks = 0;
      errors = 0;

      // fairness with all requesting, done in each grant's first cycle
      vecs[0]  = '{4'b1111, 4'b0000, 4'b0001, 2'd0, 4'b0001, 1'b0};
      vecs[1]  = '{4'b1111, 4'b0001, 4'b0000, 2'd0, 4'b0010, 1'b0};
      vecs[2]  = '{4'b1111, 4'b0000, 4'b0010, 2'd1, 4'b0010, 1'b0};
      vecs[3]  = '{4'b1111, 4'b0010, 4'b0000, 2'd1, 4'b0100, 1'b0};
      vecs[4]  = '{4'b1111, 4'b0000, 4'b0100, 2'd2, 4'b0100, 1'b0};
      vecs[5]  = '{4'b1111, 4'b0100, 4'b0000, 2'd2, 4'b1000, 1'b0};
      vecs[6]  = '{4'b1111, 4'b0000, 4'b1000, 2'd3, 4'b1000, 1'b0};
      vecs[7]  = '{4'b1111, 4'b1000, 4'b0000, 2'd3, 4'b0001, 1'b0};
      vecs[8]  = '{4'b1111, 4'b0000, 4'b0001, 2'd0, 4'b0001, 1'b0};
      vecs[9]  = '{4'b1111, 4'b0001, 4'b0000, 2'd0, 4'b0010, 1'b0};
      // service bit 1, then wrap from token 0100 to the lone bit 0
      vecs[10] = '{4'b1111, 4'b0000, 4'b0010, 2'd1, 4'b0010, 1'b0};
      vecs[11] = '{4'b1111, 4'b0010, 4'b0000, 2'd1, 4'b0100, 1'b0};
      vecs[12] = '{4'b0001, 4'b0000, 4'b0001, 2'd0, 4'b0100, 1'b0};
      vecs[13] = '{4'b0001, 4'b0001, 4'b0000, 2'd0, 4'b0010, 1'b0};
      // stray done ignored, request withdrawal releases without preempt
      vecs[14] = '{4'b0100, 4'b0000, 4'b0100, 2'd2, 4'b0010, 1'b0};
      vecs[15] = '{4'b0100, 4'b0001, 4'b0100, 2'd2, 4'b0010, 1'b0};
      vecs[16] = '{4'b0000, 4'b0000, 4'b0000, 2'd2, 4'b1000, 1'b0};
      vecs[17] = '{4'b0000, 4'b0000, 4'b0000, 2'd2, 4'b1000, 1'b0};
      vecs[18] = '{4'b0000, 4'b1111, 4'b0000, 2'd2, 4'b1000, 1'b0};
      // new requests during a grant do not disturb it
      vecs[19] = '{4'b0001, 4'b0000, 4'b0001, 2'd0, 4'b1000, 1'b0};
      vecs[20] = '{4'b1111, 4'b0000, 4'b0001, 2'd0, 4'b1000, 1'b0};
      vecs[21] = '{4'b1111, 4'b0010, 4'b0001, 2'd0, 4'b1000, 1'b0};
      vecs[22] = '{4'b1111, 4'b0001, 4'b0000, 2'd0, 4'b0010, 1'b0};

      // reset held, then released
      rst  = 1'b0;
      req  = 4'b0000;
      done = 4'b0000;
      #12;
      check_all("reset_hold", 4'b0000, 2'd0, 4'b0001, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      tick();
      check_all("reset_release", 4'b0000, 2'd0, 4'b0001, 1'b0);

      for (int i = 0; i < 23; i++) begin
         req  = vecs[i].req;
         done = vecs[i].done;
         tick();
         check_all($sformatf("vec%0d", i), vecs[i].grant, vecs[i].idx,
                   vecs[i].token, vecs[i].preempt);
      end

      // asynchronous reset in the middle of a grant
      req  = 4'b0010;
      done = 4'b0000;
      tick();
      check_all("pre_async", 4'b0010, 2'd1, 4'b0010, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      check_all("async_reset", 4'b0000, 2'd0, 4'b0001, 1'b0);
      req = 4'b0000;
      @(negedge clk);
      rst = 1'b1;

      // timeout: bit 0 holds exactly 8 cycles, then preempt and move on
      req = 4'b0011;
      for (int k = 0; k < 8; k++) begin
         tick();
         check_all($sformatf("hold%0d", k), 4'b0001, 2'd0, 4'b0001, 1'b0);
      end
      tick();
      check_all("timeout_release", 4'b0000, 2'd0, 4'b0010, 1'b1);
      tick();
      check_all("after_timeout", 4'b0010, 2'd1, 4'b0010, 1'b0);

      // done coincides with the last allowed hold cycle
      for (int k = 1; k < 8; k++) begin
         tick();
         check_all($sformatf("hold_b%0d", k), 4'b0010, 2'd1, 4'b0010, 1'b0);
      end
      done = 4'b0010;
      tick();
      check_all("simul_release", 4'b0000, 2'd1, 4'b0100, 1'b0);
      done = 4'b0000;
      req  = 4'b0000;
      tick();
      check_all("simul_idle", 4'b0000, 2'd1, 4'b0100, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
